controller_modulo: RTL and testbench
====================================

# controller_modulo

FSM that sequences `datapath_modulo` to compute `Zahl1 mod Zahl2` by repeated compare/subtract.
- Drives every datapath control strobe and the ALU mode.
- Observes only the datapath's `valid_o`.
- Provides a start/busy/done handshake to the surrounding top level.
- Includes an iteration watchdog so that `Zahl2 = 0` cannot hang the unit.

## Interface
Parameters:
- `ALU_LAT`, 1: cycles from operand presentation until `wbb` holds the ALU result (1 = combinational ALU plus `alu_c_r`).
- `MAX_ITER`, 65535: maximum number of subtractions per job before abort.
- `MODE_LT`, 3'd2: ALU mode; result bit0 = (a < b).
- `MODE_SUB`, 3'd1: ALU mode; result = a − b.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: job request; sampled only in IDLE.
- `valid_i` in 1: datapath `valid_o`.
- `busy_o` out 1: high from the cycle after start until DONE/ERR completes.
- `done_o` out 1: one-cycle pulse; datapath `ergebnis_o` holds the remainder.
- `err_o` out 1: one-cycle pulse; watchdog abort, result invalid.
- `alu_mode_o` out 3: to datapath `alu_mode_i`.
- `wren_update_zahlen_o`, `wren_zahl1_to_erg_o`, `wren_term_erg_o`, `wren_res_to_erg_o` out 1 each: datapath write-back strobes.
- `erg_to_alu_a_o`, `zahl2_to_alu_b_o` out 1 each: datapath operand selects.
- `check_for_termination_o` out 1: datapath termination qualifier.

## Operation
- All outputs are Moore-decoded from state, except the CHECK branch, which uses `valid_i` combinationally.
- Strobes not listed for a state are 0.
- States and actions:
  - IDLE: `busy_o` = 0. `start_i` = 1 → LOAD and clear `iter_cnt`.
  - LOAD: `wren_update_zahlen_o` = 1 → INIT.
  - INIT: `wren_zahl1_to_erg_o` = 1 → CMP.
  - CMP: `erg_to_alu_a_o` = `zahl2_to_alu_b_o` = 1, `alu_mode_o` = `MODE_LT`.
    - Held for `ALU_LAT`+1 cycles, counted by `wait_cnt`.
    - `wren_term_erg_o` = 1 in the last of these cycles only → CHECK.
  - CHECK: `check_for_termination_o` = 1.
    - `valid_i` = 1 → DONE.
    - Otherwise, `iter_cnt` == `MAX_ITER` → ERR.
    - Otherwise → SUB.
  - SUB: operand selects = 1, `alu_mode_o` = `MODE_SUB`.
    - Held for `ALU_LAT`+1 cycles.
    - `wren_res_to_erg_o` = 1 in the last cycle only, then `iter_cnt` += 1 → CMP.
  - DONE: `done_o` = 1, `check_for_termination_o` = 1 → IDLE.
  - ERR: `err_o` = 1 → IDLE.
- `alu_mode_o` = 3'd0 outside CMP/SUB.
- `iter_cnt` width is clog2(`MAX_ITER`+1); it saturates and never wraps.
- `start_i` outside IDLE is ignored and is not queued.
- `start_i` asserted in the same cycle as the DONE/ERR pulse is ignored; it is accepted in the following IDLE cycle.
- Operand semantics (signedness, range) belong to the ALU; the controller is data-agnostic.
- `Zahl2` = 0: LT never fires, so the watchdog drives the job to ERR after `MAX_ITER` subtractions.

## Timing
- Reset (`rst_i` low, any time, including mid-job): state → IDLE, `wait_cnt` = `iter_cnt` = 0, all outputs 0.
  - No pulse is emitted on reset.
  - After release, the first `start_i` is accepted on the first rising edge.
- Requester holds `Zahl1_i`/`Zahl2_i` valid from the start cycle S until `busy_o` falls.
  - The datapath input registers capture the operands at the end of S.
  - LOAD (S+1) copies them into the working registers.
- Let L = `ALU_LAT` and k = number of subtractions:
  - CMP occupies S+3 … S+3+L.
  - CHECK is at S+4+L.
  - One loop iteration takes 2L+3 cycles.
  - DONE at S+5+L+k(2L+3).
  - With L = 1: DONE at S+6+5k.
- `busy_o` = 1 from S+1 through the DONE/ERR cycle inclusive.
- ERR with L = 1 occurs at S+6+5·`MAX_ITER`.

## Test plan
- Reset values: hold `rst_i` low for 3 cycles → all outputs 0, `busy_o` = 0. Assert `rst_i` low at S+9 of a 17 mod 5 job → outputs 0 immediately, asynchronously; the next job runs normally.
- 17 mod 5, L = 1: `start_i` at S → 3 subtractions, `done_o` at S+21, `ergebnis_o` = 2, `busy_o` low at S+22.
- 3 mod 7: no subtraction, `done_o` at S+6, `ergebnis_o` = 3. Check that no SUB strobe ever fires.
- 10 mod 5: `done_o` at S+16, `ergebnis_o` = 0. 5 mod 5: `done_o` at S+11, result 0.
- `MAX_ITER` = 4, 9 mod 0: `err_o` pulse at S+26, no `done_o`, then IDLE. Repeat with 3 mod 0 → same timing.
- Back-to-back jobs: `start_i` held high continuously → second job's S is exactly 1 cycle after the first DONE. `start_i` pulsed mid-job → ignored, the job result is unchanged.

Source files
------------

// File: rtl/controller_modulo.sv
// controller_modulo: FSM sequencing datapath_modulo to compute Zahl1 mod Zahl2 by compare/subtract,
// with a start/busy/done handshake and an iteration watchdog against Zahl2 = 0.
module controller_modulo #(
  parameter int ALU_LAT = 1,
  parameter int MAX_ITER = 65535,
  parameter logic [2:0] MODE_LT = 3'd2,
  parameter logic [2:0] MODE_SUB = 3'd1
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       valid_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [2:0] alu_mode_o,
  output logic       wren_update_zahlen_o,
  output logic       wren_zahl1_to_erg_o,
  output logic       wren_term_erg_o,
  output logic       wren_res_to_erg_o,
  output logic       erg_to_alu_a_o,
  output logic       zahl2_to_alu_b_o,
  output logic       check_for_termination_o
);
  localparam int WW = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_LAT);
  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] INIT  = 3'd2;
  localparam logic [2:0] CMP   = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] SUB   = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam logic [2:0] ERR   = 3'd7;
  logic [2:0] state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] iter_cnt;
  logic in_alu, alu_last;
  assign in_alu = state == CMP || state == SUB;
  assign alu_last = wait_cnt == WAIT_LAST;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_i ? LOAD : IDLE;
      LOAD:    state_nxt = INIT;
      INIT:    state_nxt = CMP;
      CMP:     state_nxt = alu_last ? CHECK : CMP;
      CHECK:   state_nxt = valid_i ? DONE : iter_cnt == ITER_MAX ? ERR : SUB;
      SUB:     state_nxt = alu_last ? CMP : SUB;
      default: state_nxt = IDLE;
    endcase
  end
  // wait_cnt runs only while an ALU operation is pending; iter_cnt saturates instead of wrapping
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      wait_cnt <= '0;
      iter_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= in_alu && !alu_last ? wait_cnt + 1'b1 : '0;
      if (state == IDLE && start_i)
        iter_cnt <= '0;
      else if (state == SUB && alu_last && iter_cnt != ITER_MAX)
        iter_cnt <= iter_cnt + 1'b1;
    end
  end
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign err_o = state == ERR;
  assign alu_mode_o = state == CMP ? MODE_LT : state == SUB ? MODE_SUB : 3'd0;
  assign wren_update_zahlen_o = state == LOAD;
  assign wren_zahl1_to_erg_o = state == INIT;
  assign wren_term_erg_o = state == CMP && alu_last;
  assign wren_res_to_erg_o = state == SUB && alu_last;
  assign erg_to_alu_a_o = in_alu;
  assign zahl2_to_alu_b_o = in_alu;
  assign check_for_termination_o = state == CHECK || state == DONE;
endmodule

// File: tb/tb_controller_modulo.sv
// tb_controller_modulo: drives controller_modulo through a behavioural datapath and checks every
// cycle against a schedule derived from the job timing rules, plus literal per-job expectations.
module tb_controller_modulo;
  localparam int MAX_ITER = 4;
  logic clk = 0;
  logic rst_i = 0;
  logic start_i = 0;
  logic valid;
  logic busy_o, done_o, err_o;
  logic [2:0] alu_mode_o;
  logic wren_update_zahlen_o, wren_zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o;
  logic erg_to_alu_a_o, zahl2_to_alu_b_o, check_for_termination_o;
  logic [31:0] zahl1 = 0, zahl2 = 0;
  logic [31:0] in1 = 0, in2 = 0, a_r = 0, b_r = 0, erg = 0, alu_r = 0;
  logic term = 0;
  logic [12:0] dutvec;
  int cyc = 0, res_cnt = 0;
  int vectors = 0, miscompares = 0;
  bit active = 0, jerr = 0;
  int js = 0, jend = 0;
  logic [31:0] ja = 0, jb = 0;

  controller_modulo #(.ALU_LAT(1), .MAX_ITER(MAX_ITER), .MODE_LT(3'd2), .MODE_SUB(3'd1)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .alu_mode_o(alu_mode_o),
    .wren_update_zahlen_o(wren_update_zahlen_o), .wren_zahl1_to_erg_o(wren_zahl1_to_erg_o),
    .wren_term_erg_o(wren_term_erg_o), .wren_res_to_erg_o(wren_res_to_erg_o),
    .erg_to_alu_a_o(erg_to_alu_a_o), .zahl2_to_alu_b_o(zahl2_to_alu_b_o),
    .check_for_termination_o(check_for_termination_o)
  );

  always #5 clk = ~clk;

  assign dutvec = {busy_o, done_o, err_o, alu_mode_o, wren_update_zahlen_o, wren_zahl1_to_erg_o,
                   wren_term_erg_o, wren_res_to_erg_o, erg_to_alu_a_o, zahl2_to_alu_b_o,
                   check_for_termination_o};

  // behavioural datapath: input registers, working registers, registered ALU result
  always @(posedge clk) begin
    cyc <= cyc + 1;
    in1 <= zahl1;
    in2 <= zahl2;
    if (wren_update_zahlen_o) begin a_r <= in1; b_r <= in2; end
    if (wren_zahl1_to_erg_o) erg <= a_r;
    else if (wren_res_to_erg_o) erg <= alu_r;
    alu_r <= alu_mode_o == 3'd2 ? {31'b0, erg < b_r} : alu_mode_o == 3'd1 ? erg - b_r : 32'd0;
    if (wren_term_erg_o) term <= alu_r[0];
    if (wren_res_to_erg_o) res_cnt <= res_cnt + 1;
  end
  assign valid = check_for_termination_o & term;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // expected outputs at offset t from the start cycle, job ending (DONE/ERR) at offset tend
  function automatic logic [12:0] sched(int t, int tend, bit e);
    logic dn, er, up, ze, tw, rw, sel, ck;
    logic [2:0] md;
    int r;
    dn = t == tend && !e;
    er = t == tend && e;
    up = t == 1;
    ze = t == 2;
    sel = 0; md = 0; tw = 0; rw = 0; ck = 0;
    if (t == tend) ck = !e;
    else if (t == 3 || t == 4) begin sel = 1; md = 3'd2; tw = t == 4; end
    else if (t == 5) ck = 1;
    else if (t > 5) begin
      r = (t - 6) % 5;
      sel = r < 4;
      md = r < 2 ? 3'd1 : r < 4 ? 3'd2 : 3'd0;
      rw = r == 1;
      tw = r == 3;
      ck = r == 4;
    end
    return {1'b1, dn, er, md, up, ze, tw, rw, sel, sel, ck};
  endfunction

  always @(negedge clk) begin
    logic [12:0] ex;
    ex = '0;
    if (!rst_i) active = 0;
    else if (active) ex = sched(cyc - js, jend, jerr);
    chk("cycle_outputs", {19'b0, dutvec}, {19'b0, ex});
    if (rst_i && active && cyc - js == jend && !jerr) chk("remainder", erg, ja % jb);
    if (rst_i) begin
      if (active && cyc - js == jend) active = 0;
      else if (!active && start_i) begin
        active = 1; js = cyc; ja = zahl1; jb = zahl2;
        if (zahl2 != 0 && zahl1 / zahl2 <= MAX_ITER) begin jend = 6 + 5 * int'(zahl1 / zahl2); jerr = 0; end
        else begin jend = 6 + 5 * MAX_ITER; jerr = 1; end
      end
    end
  end

  task automatic wait_end(output int n);
    n = 0;
    while (!(done_o || err_o) && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int exp_off,
                         input logic [31:0] exp_res, input bit exp_err, input int exp_sub, input string nm);
    int s, n, r0;
    @(posedge clk); #1;
    zahl1 = a; zahl2 = b; start_i = 1; s = cyc; r0 = res_cnt;
    @(posedge clk); #1;
    start_i = 0;
    wait_end(n);
    chk({nm, "_end_offset"}, cyc - s, exp_off);
    chk({nm, "_done"}, done_o, !exp_err);
    chk({nm, "_err"}, err_o, exp_err);
    if (!exp_err) chk({nm, "_result"}, erg, exp_res);
    chk({nm, "_subs"}, res_cnt - r0, exp_sub);
    @(posedge clk); #1;
    chk({nm, "_busy_after"}, busy_o, 0);
  endtask

  initial begin
    int s, d, n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {19'b0, dutvec}, 0);
    rst_i = 1;
    run_job(17, 5, 21, 2, 0, 3, "17mod5");
    run_job(3, 7, 6, 3, 0, 0, "3mod7");
    run_job(10, 5, 16, 0, 0, 2, "10mod5");
    run_job(5, 5, 11, 0, 0, 1, "5mod5");
    run_job(9, 0, 26, 0, 1, 4, "9mod0");
    run_job(3, 0, 26, 0, 1, 4, "3mod0");
    // start held high: second job starts in the IDLE cycle right after DONE
    @(posedge clk); #1;
    zahl1 = 17; zahl2 = 5; start_i = 1; s = cyc;
    @(posedge clk); #1;
    wait_end(n);
    d = cyc;
    chk("b2b_first_done", cyc - s, 21);
    @(posedge clk); #1;
    chk("b2b_idle_gap", busy_o, 0);
    s = cyc;
    @(posedge clk); #1;
    start_i = 0;
    wait_end(n);
    chk("b2b_second_done", cyc - d, 22);
    chk("b2b_second_result", erg, 2);
    // mid-job start pulse is neither obeyed nor queued
    @(posedge clk); #1;
    zahl1 = 10; zahl2 = 5; start_i = 1; s = cyc;
    @(posedge clk); #1;
    start_i = 0;
    repeat (7) @(posedge clk);
    #1;
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    wait_end(n);
    chk("pulse_done_offset", cyc - s, 16);
    chk("pulse_result", erg, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pulse_not_queued", busy_o, 0);
    // asynchronous reset in the middle of a job
    @(posedge clk); #1;
    zahl1 = 17; zahl2 = 5; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    repeat (8) @(posedge clk);
    #3;
    rst_i = 0;
    #1;
    chk("midjob_reset_outputs", {19'b0, dutvec}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1;
    run_job(3, 7, 6, 3, 0, 0, "after_reset_3mod7");
    run_job(17, 5, 21, 2, 0, 3, "after_reset_17mod5");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
